// File: rtl/shared_wire_arbiter.sv
// Round-robin owner of one shared single-bit wire with bounded hold time.
// Optional SHARED_WIRE_PARK_EN keeps the last driven bit on the wire in IDLE.
module shared_wire_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 out
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    cand;
    logic [PW-1:0]   win;
    logic            any_cand;
    logic            wire_val;

    // First set bit of cand scanning start, start+1, ... modulo N.
    function automatic logic [PW-1:0] pick(
        input logic [N-1:0]  c,
        input logic [PW-1:0] start
    );
        logic [PW:0]   sum;
        logic [PW-1:0] k;
        logic          hit;
        k   = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, start} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            if (!hit && c[sum[PW-1:0]]) begin
                hit = 1'b1;
                k   = sum[PW-1:0];
            end
        end
        return k;
    endfunction

    // The owner never competes against itself, so a preempted owner goes last.
    assign cand     = req & ~gnt_q;
    assign any_cand = |cand;
    assign win      = pick(cand, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == OWN && cnt_q != CW'(MAX_HOLD))
            cnt_d = cnt_q + CW'(1);
        if ((state_q == IDLE && any_cand) ||
            (state_q == OWN && any_cand &&
             (!req[owner_q] || cnt_q == CW'(MAX_HOLD)))) begin
            state_d = OWN;
            gnt_d   = N'(1) << win;
            owner_d = win;
            ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
            cnt_d   = CW'(1);
        end else if (state_q == OWN && !req[owner_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
        end
    end

`ifdef SHARED_WIRE_PARK_EN
    logic park_q, park_d;
    assign park_d = (state_q == OWN) ? din[owner_q] : park_q;
    assign wire_val = (state_q == OWN) ? din[owner_q] : park_q;
`else
    assign wire_val = (state_q == OWN) ? din[owner_q] : 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
`ifdef SHARED_WIRE_PARK_EN
            park_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef SHARED_WIRE_PARK_EN
            park_q  <= park_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = |gnt_q;
    assign out   = wire_val;
endmodule

// File: tb/tb_shared_wire_arbiter.sv
// Directed self-checking bench for shared_wire_arbiter (N=4, MAX_HOLD=8).
module tb_shared_wire_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       out;

    int total = 0;
    int fails = 0;

    shared_wire_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;
        logic       b;
        logic       park_exp;
`ifdef SHARED_WIRE_PARK_EN
        park_exp = 1'b1;
`else
        park_exp = 1'b0;
`endif
        reset = 1'b1;
        req   = '0;
        din   = '0;
        step();
        reset = 1'b0;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_gnt", gnt, 4'b0000);
            chk("idle_busy", busy, 0);
            chk("idle_out", out, 0);
            chk("idle_owner", owner, 0);
        end

        // Single requester 2, data path is combinational.
        req = 4'b0100;
        step();
        chk("r2_gnt", gnt, 4'b0100);
        chk("r2_owner", owner, 2);
        chk("r2_busy", busy, 1);
        for (int i = 0; i < 12; i++) begin
            b   = i[0];
            din = {~b, b, ~b, ~b};
            #2;
            chk("r2_out", out, b);
            step();
            chk("r2_keep", gnt, 4'b0100);
        end

        // All requesting from reset: 8-cycle rotation, no gaps.
        req   = 4'b1111;
        reset = 1'b1;
        step();
        chk("rr_rst_gnt", gnt, 4'b0000);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            e = 4'b0001 << ((c / 8) % 4);
            chk("rr_gnt", gnt, e);
            chk("rr_busy", busy, 1);
        end

        // Owner 1 releases while 3 waits: direct handoff.
        req   = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        chk("ho_gnt1", gnt, 4'b0010);
        req = 4'b1000;
        step();
        chk("ho_gnt3", gnt, 4'b1000);
        chk("ho_busy", busy, 1);
        chk("ho_ptr", dut.ptr_q, 0);

        // ptr = 1 in IDLE, 0 and 3 rise together.
        req   = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0001;
        step();
        chk("pt_gnt0", gnt, 4'b0001);
        req = 4'b0000;
        step();
        chk("pt_idle", gnt, 4'b0000);
        chk("pt_ptr", dut.ptr_q, 1);
        req = 4'b1001;
        step();
        chk("pt_gnt3", gnt, 4'b1000);
        req = 4'b0001;
        step();
        chk("pt_gnt0b", gnt, 4'b0001);
        chk("pt_owner", owner, 0);

        // Reset mid-ownership of requester 2.
        req = 4'b0100;
        step();
        step();
        chk("mr_own2", owner, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_gnt", gnt, 4'b0000);
        chk("mr_owner", owner, 0);
        chk("mr_busy", busy, 0);
        chk("mr_out", out, 0);
        req = 4'b0110;
        step();
        chk("mr_gnt1", gnt, 4'b0010);
        chk("mr_owner1", owner, 1);

        // Wire level in IDLE after an owner last drove 1.
        din = 4'b0010;
        #2;
        chk("pk_drive", out, 1);
        req = 4'b0000;
        step();
        chk("pk_idle", gnt, 4'b0000);
        din = 4'b0000;
        #2;
        chk("pk_out", out, park_exp);
        step();
        chk("pk_out2", out, park_exp);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("pk_rst", out, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/shared_wire_arbiter.md
# shared_wire_arbiter

Round-robin arbiter that shares one single-bit output wire among `N` requesters. A requester that holds the grant drives the shared wire combinationally, with zero latency, exactly as a plain wire would. The arbiter schedules ownership, enforces a maximum hold time when other requesters are waiting, and hands off between owners with no idle cycle. It sits between the per-lane bit sources and the single shared `out` net.

## Interface
- `N`, default 4: number of requesters; minimum 2.
- `MAX_HOLD`, default 8: maximum owned cycles before preemption while others are waiting; minimum 1.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  N  per-requester ownership request; level-sensitive.
- `din`  input  N  per-requester data bit; `din[i]` is used only while `i` owns the wire.
- `gnt`  output  N  one-hot grant, registered; all-zero when idle.
- `owner`  output  $clog2(N)  index of the current owner, registered; holds its last value while idle.
- `busy`  output  1  high while any grant is active; equals `|gnt`.
- `out`  output  1  the shared wire.

## Operation
- Two states:
  - IDLE: no grant is active.
  - OWN: exactly one `gnt` bit is set.
- Round-robin pointer `ptr`:
  - The winner is the first set bit of `req` scanning `ptr, ptr+1, …, N-1, 0, …` (modulo N).
  - On every new grant to index `k`, `ptr` becomes `(k+1) mod N`.
- Hold counter `cnt`:
  - Loaded with 1 on every new grant.
  - Increments each owned cycle and saturates at `MAX_HOLD`.
- IDLE → OWN: if `|req`, the winner is granted at the next edge.
- OWN, owner deasserts `req[owner]`:
  - If any other `req` bit is set, the grant moves directly to the next winner at the next edge.
  - Otherwise the block returns to IDLE.
- OWN, `cnt == MAX_HOLD` and any other `req` bit set: preemption. The grant moves to the next winner at the next edge, even though the owner is still requesting.
- OWN, `cnt == MAX_HOLD` and no other requester: the owner keeps the grant and `cnt` stays at `MAX_HOLD`.
- `out`:
  - In OWN: `din[owner]`, purely combinational from `din`.
  - In IDLE: 0, unless the Configuration feature is enabled.
- Width rules:
  - `cnt` is `$clog2(MAX_HOLD+1)` bits.
  - The `ptr` increment wraps from N-1 to 0.
  - Non-power-of-two `N` is legal; `ptr` never holds a value ≥ N.

## Timing
- Reset values after a reset edge:
  - `gnt = 0`, `owner = 0`, `busy = 0`, `out = 0`.
  - `ptr = 0`, `cnt = 0`, state IDLE.
- Reset dominates: at any edge with `reset = 1`, all state returns to reset values regardless of `req`, including mid-ownership.
- Request-to-grant latency:
  - From IDLE: 1 cycle. A request sampled at edge t appears on `gnt` after edge t.
  - Handoff: 0 idle cycles between owners. `gnt` changes from one one-hot value to another in a single edge.
- Release latency: `gnt` drops at the first edge where the owner's `req` is sampled low.
- Data latency: `out` follows `din[owner]` within the same cycle; there is no register on the data path.
- Simultaneous events:
  - Owner release and new requests at the same edge resolve as a handoff.
  - A request rising at the same edge as a preemption takes part in that arbitration.

## Configuration
- `SHARED_WIRE_PARK_EN` defined:
  - A 1-bit register captures `out` on every owned cycle.
  - In IDLE, `out` holds that last driven value; the wire is parked, not released to 0.
  - Reset clears the park register to 0.
- Undefined:
  - No park register is built.
  - `out` is 0 in IDLE.

## Test plan
- Reset, then `req = 0` for 10 cycles → `gnt = 0`, `busy = 0`, `out = 0`, `owner = 0` throughout.
- `req = 4'b0100` held, `din[2]` toggled every cycle → after one edge `gnt = 4'b0100`, `owner = 2`; `out` equals `din[2]` in the same cycle on every cycle; `din[0]`, `din[1]` and `din[3]` have no effect.
- `req = 4'b1111` held from reset, `MAX_HOLD = 8` → owners 0, 1, 2, 3, 0 in turn, each granted for exactly 8 cycles, with no cycle where `gnt = 0`.
- Owner 1 deasserts `req[1]` while `req[3] = 1` → at the next edge `gnt = 4'b1000`, `busy` stays 1, `ptr = 0`.
- `ptr = 1` in IDLE, `req[0]` and `req[3]` rise together → `gnt = 4'b1000` first; after release, `gnt = 4'b0001`.
- Reset pulsed for one cycle while `owner = 2`, then `req = 4'b0110` → reset values after the reset edge, then `gnt = 4'b0010`.
- With `SHARED_WIRE_PARK_EN`: owner ends with `din = 1`, then all requests drop → `out` stays 1 in IDLE until the next grant or reset.
